ps2_host_tx: RTL and testbench
==============================

PS2_HOST_TX -- requirements
Module: ps2_host_tx

Interface
REQ-001 Parameter INHIBIT_CYC, default 2400, clk_bus cycles the host holds PS2 clock low before a request (100 us at 24 MHz).
REQ-002 Parameter TIMEOUT_CYC, default 48000, maximum clk_bus cycles allowed between consecutive device clock falling edges, and from request to first edge.
REQ-003 clk_bus  in  1  single system clock; all logic rising-edge.
REQ-004 bus_reset  in  1  reset, asynchronous and active-high.
REQ-005 tx_data  in  8  byte to send to the device (LED command, reset, typematic).
REQ-006 tx_start  in  1  one-cycle request; tx_data is sampled in the same cycle.
REQ-007 tx_busy  out  1  high from the cycle after an accepted tx_start until return to IDLE.
REQ-008 tx_done  out  1  one-cycle pulse: byte sent and device ACK seen.
REQ-009 tx_error  out  1  one-cycle pulse: timeout or missing ACK.
REQ-010 ps2_clk_i / ps2_dat_i  in  1 each  raw PS2 line levels, asynchronous.
REQ-011 ps2_clk_oe / ps2_dat_oe  out  1 each  1 = drive line low (open-drain), 0 = release.

Function
REQ-012 ps2_clk_i and ps2_dat_i shall pass through 2-flop synchronizers; a falling edge is synchronized-clock 1->0 between consecutive cycles.
REQ-013 States: IDLE, INHIBIT, REQUEST, SHIFT, ACK, WAIT_REL; transitions occur only as listed below.
REQ-014 IDLE: both oe=0; tx_start=1 latches tx_data, computes odd parity (~^tx_data), clears the bit counter, and enters INHIBIT.
REQ-015 tx_start outside IDLE shall be ignored with no effect on the transfer in progress.
REQ-016 INHIBIT: clk_oe=1, dat_oe=0 for exactly INHIBIT_CYC cycles; then enter REQUEST.
REQ-017 REQUEST: dat_oe=1 (start bit 0), clk_oe=0 from the entry cycle; the timeout counter is cleared; enter SHIFT.
REQ-018 SHIFT: on each device falling edge, the bit counter increments and the line is set to the next frame bit.
REQ-019 Frame bits on successive falling edges: edges 1-8 data bits LSB first, edge 9 parity, edge 10 stop (dat_oe=0); a data bit value 1 shall mean dat_oe=0, and 0 shall mean dat_oe=1.
REQ-020 After edge 10, enter ACK; on the next falling edge, synchronized ps2_dat_i=0 is a valid ACK and =1 is a failure.
REQ-021 WAIT_REL: after a valid ACK, wait until both synchronized lines are 1, then pulse tx_done and return to IDLE.
REQ-022 The timeout counter shall clear on every device falling edge; reaching TIMEOUT_CYC in REQUEST, SHIFT, ACK or WAIT_REL aborts the transfer.
REQ-023 Abort or missing ACK: release both lines, pulse tx_error for one cycle, and return to IDLE; tx_done and tx_error are never both high.
REQ-024 tx_busy shall fall in the same cycle that tx_done or tx_error pulses.
REQ-025 The counters shall saturate and never wrap; the bit counter shall be 4 bits and the timeout counter wide enough for TIMEOUT_CYC.
REQ-026 The device holding the clock low during INHIBIT shall be ignored (host has priority).

Reset
REQ-027 Asserting bus_reset shall immediately force IDLE with ps2_clk_oe=0, ps2_dat_oe=0, tx_busy=0, tx_done=0, tx_error=0, and counters cleared, including mid-frame; no tx_error pulse results.
REQ-028 Synchronizer flops shall reset to 1 (idle line level) so that no false edge occurs on release.

Verification
REQ-029 tx_data=0xED -> after 2400 cycles clk released; dat_oe sequence on edges 1-10 is 0,1,0,0,1,0,0,0,0,0 (bits 1,0,1,1,0,1,1,1, parity 1, stop); model ACK=0 -> tx_done pulse once.
REQ-030 tx_data=0xF4 -> parity bit 0 (dat_oe=1 on edge 9); ACK=0 -> tx_done pulse once.
REQ-031 Device model keeps data high at the ACK edge -> tx_error pulse, no tx_done, both oe=0.
REQ-032 Device stops clocking after edge 5 -> tx_error exactly TIMEOUT_CYC cycles after edge 5, then IDLE.
REQ-033 bus_reset asserted at edge 4 -> both oe=0 asynchronously, tx_busy=0, no pulses; a new tx_start then completes normally.
REQ-034 Second tx_start during SHIFT -> ignored; the first byte's frame is unchanged and exactly one tx_done is produced.

Source files
------------

// File: rtl/ps2_host_tx.sv
// PS/2 host-to-device byte transmitter.
// Inhibits the bus, issues a request-to-send, shifts the frame out on the
// device's falling clock edges, then checks the device ACK. Lines are
// open-drain: an *_oe of 1 pulls the line low.
module ps2_host_tx #(
  parameter int unsigned INHIBIT_CYC = 2400,
  parameter int unsigned TIMEOUT_CYC = 48000
) (
  input  logic       clk_bus,
  input  logic       bus_reset,
  input  logic [7:0] tx_data,
  input  logic       tx_start,
  output logic       tx_busy,
  output logic       tx_done,
  output logic       tx_error,
  input  logic       ps2_clk_i,
  input  logic       ps2_dat_i,
  output logic       ps2_clk_oe,
  output logic       ps2_dat_oe
);

  localparam int unsigned InhW = (INHIBIT_CYC > 1) ? $clog2(INHIBIT_CYC + 1) : 1;
  localparam int unsigned ToW  = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC + 1) : 1;

  typedef enum logic [2:0] {
    StIdle,
    StInhibit,
    StRequest,
    StShift,
    StAck,
    StWaitRel
  } state_e;

  state_e              r_state, w_state_nxt;
  logic                r_clk_s1, r_clk_s2, r_clk_prev;
  logic                r_dat_s1, r_dat_s2;
  logic [7:0]          r_data, w_data_nxt;
  logic                r_parity, w_parity_nxt;
  logic [3:0]          r_bit_cnt, w_bit_cnt_nxt;
  logic [InhW-1:0]     r_inh_cnt, w_inh_cnt_nxt;
  logic [ToW-1:0]      r_to_cnt, w_to_cnt_nxt;
  logic                r_dat_oe, w_dat_oe_nxt;
  logic                r_done, w_done_nxt;
  logic                r_error, w_error_nxt;

  logic                w_fall;
  logic                w_to_expire;
  logic                w_inh_last;
  logic [3:0]          w_bit_inc;
  logic [2:0]          w_bit_idx;

  // Two-flop synchronizers plus a delayed copy of the clock for edge detection.
  // All reset to the idle (released) level so reset release cannot fake an edge.
  always_ff @(posedge clk_bus or posedge bus_reset) begin
    if (bus_reset) begin
      r_clk_s1   <= 1'b1;
      r_clk_s2   <= 1'b1;
      r_clk_prev <= 1'b1;
      r_dat_s1   <= 1'b1;
      r_dat_s2   <= 1'b1;
    end else begin
      r_clk_s1   <= ps2_clk_i;
      r_clk_s2   <= r_clk_s1;
      r_clk_prev <= r_clk_s2;
      r_dat_s1   <= ps2_dat_i;
      r_dat_s2   <= r_dat_s1;
    end
  end

  assign w_fall      = r_clk_prev & ~r_clk_s2;
  // Abort when the idle-cycle count would reach TIMEOUT_CYC at this edge.
  assign w_to_expire = (32'(r_to_cnt) + 32'd1) >= TIMEOUT_CYC;
  assign w_inh_last  = (32'(r_inh_cnt) + 32'd1) >= INHIBIT_CYC;
  assign w_bit_inc   = (r_bit_cnt == 4'hF) ? r_bit_cnt : r_bit_cnt + 4'd1;
  // Edges 1..8 carry data bits 0..7; 3-bit wrap maps edge 8 onto bit 7.
  assign w_bit_idx   = w_bit_inc[2:0] - 3'd1;

  // State and datapath registers.
  always_ff @(posedge clk_bus or posedge bus_reset) begin
    if (bus_reset) begin
      r_state   <= StIdle;
      r_data    <= '0;
      r_parity  <= 1'b0;
      r_bit_cnt <= '0;
      r_inh_cnt <= '0;
      r_to_cnt  <= '0;
      r_dat_oe  <= 1'b0;
      r_done    <= 1'b0;
      r_error   <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_data    <= w_data_nxt;
      r_parity  <= w_parity_nxt;
      r_bit_cnt <= w_bit_cnt_nxt;
      r_inh_cnt <= w_inh_cnt_nxt;
      r_to_cnt  <= w_to_cnt_nxt;
      r_dat_oe  <= w_dat_oe_nxt;
      r_done    <= w_done_nxt;
      r_error   <= w_error_nxt;
    end
  end

  // Next-state logic: frame sequencing, timeout supervision and result pulses.
  always_comb begin
    w_state_nxt   = r_state;
    w_data_nxt    = r_data;
    w_parity_nxt  = r_parity;
    w_bit_cnt_nxt = r_bit_cnt;
    w_inh_cnt_nxt = r_inh_cnt;
    w_to_cnt_nxt  = (32'(r_to_cnt) >= TIMEOUT_CYC) ? r_to_cnt : r_to_cnt + ToW'(1);
    w_dat_oe_nxt  = r_dat_oe;
    w_done_nxt    = 1'b0;
    w_error_nxt   = 1'b0;

    unique case (r_state)
      StIdle: begin
        w_dat_oe_nxt = 1'b0;
        w_to_cnt_nxt = '0;
        if (tx_start) begin
          w_data_nxt    = tx_data;
          w_parity_nxt  = ~^tx_data;
          w_bit_cnt_nxt = '0;
          w_inh_cnt_nxt = '0;
          w_state_nxt   = StInhibit;
        end
      end
      // Device clock activity is ignored here: the host is holding the clock.
      StInhibit: begin
        w_to_cnt_nxt = '0;
        if (w_inh_last) begin
          w_dat_oe_nxt = 1'b1;
          w_state_nxt  = StRequest;
        end else begin
          w_inh_cnt_nxt = r_inh_cnt + InhW'(1);
        end
      end
      StRequest: begin
        w_to_cnt_nxt = '0;
        w_state_nxt  = StShift;
      end
      StShift: begin
        if (w_fall) begin
          w_to_cnt_nxt  = '0;
          w_bit_cnt_nxt = w_bit_inc;
          case (w_bit_inc)
            4'd1, 4'd2, 4'd3, 4'd4,
            4'd5, 4'd6, 4'd7, 4'd8: w_dat_oe_nxt = ~r_data[w_bit_idx];
            4'd9:                   w_dat_oe_nxt = ~r_parity;
            default: begin
              w_dat_oe_nxt = 1'b0;
              w_state_nxt  = StAck;
            end
          endcase
        end else if (w_to_expire) begin
          w_dat_oe_nxt = 1'b0;
          w_error_nxt  = 1'b1;
          w_state_nxt  = StIdle;
        end
      end
      StAck: begin
        if (w_fall) begin
          w_to_cnt_nxt = '0;
          if (!r_dat_s2) begin
            w_state_nxt = StWaitRel;
          end else begin
            w_error_nxt = 1'b1;
            w_state_nxt = StIdle;
          end
        end else if (w_to_expire) begin
          w_error_nxt = 1'b1;
          w_state_nxt = StIdle;
        end
      end
      StWaitRel: begin
        if (r_clk_s2 && r_dat_s2) begin
          w_done_nxt  = 1'b1;
          w_state_nxt = StIdle;
        end else if (w_to_expire) begin
          w_error_nxt = 1'b1;
          w_state_nxt = StIdle;
        end
      end
      default: begin
        w_dat_oe_nxt = 1'b0;
        w_state_nxt  = StIdle;
      end
    endcase
  end

  assign ps2_clk_oe = (r_state == StInhibit);
  assign ps2_dat_oe = r_dat_oe;
  assign tx_busy    = (r_state != StIdle);
  assign tx_done    = r_done;
  assign tx_error   = r_error;

endmodule

// File: tb/tb_ps2_host_tx.sv
// Bench for ps2_host_tx: an open-drain bus with a scripted PS/2 device, a
// per-cycle behavioural model of busy / inhibit / request timing, frame
// contents computed from the byte, and literal expectations for known bytes.
module tb_ps2_host_tx;

  localparam int unsigned INH  = 40;
  localparam int unsigned TO   = 300;
  localparam int unsigned HALF = 8;

  logic       clk_bus = 1'b0;
  logic       bus_reset;
  logic [7:0] tx_data;
  logic       tx_start;
  logic       tx_busy, tx_done, tx_error;
  logic       ps2_clk_oe, ps2_dat_oe;
  logic       dev_clk, dev_dat;
  logic       line_clk, line_dat;

  // Wired-AND bus: either side may pull a line low.
  assign line_clk = dev_clk & ~ps2_clk_oe;
  assign line_dat = dev_dat & ~ps2_dat_oe;

  ps2_host_tx #(
    .INHIBIT_CYC(INH),
    .TIMEOUT_CYC(TO)
  ) dut (
    .clk_bus   (clk_bus),
    .bus_reset (bus_reset),
    .tx_data   (tx_data),
    .tx_start  (tx_start),
    .tx_busy   (tx_busy),
    .tx_done   (tx_done),
    .tx_error  (tx_error),
    .ps2_clk_i (line_clk),
    .ps2_dat_i (line_dat),
    .ps2_clk_oe(ps2_clk_oe),
    .ps2_dat_oe(ps2_dat_oe)
  );

  always #5 clk_bus = ~clk_bus;

  int unsigned n_pass  = 0;
  int unsigned n_total = 0;
  int unsigned cyc     = 0;
  int unsigned n_done  = 0;
  int unsigned n_err   = 0;
  int unsigned err_cyc = 0;
  int unsigned inh_run = 0;
  int          m_inh   = 0;
  bit          m_busy  = 1'b0;
  bit          m_req   = 1'b0;
  bit          s_start = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
  endtask

  // Expected dat_oe after device edges 1..10: inverted data LSB first, inverted
  // odd-parity bit (which equals the XOR of the data), then released stop bit.
  function automatic logic [9:0] model_frame(input logic [7:0] d);
    logic [9:0] f;
    for (int k = 0; k < 8; k++) f[k] = ~d[k];
    f[8] = ^d;
    f[9] = 1'b0;
    return f;
  endfunction

  // One clock: sample the start request at the rising edge, then advance the
  // model and compare outputs at the falling edge.
  task automatic tick();
    @(posedge clk_bus);
    s_start = tx_start;
    cyc++;
    @(negedge clk_bus);
    if (bus_reset) begin
      m_busy = 1'b0;
      m_inh  = 0;
      m_req  = 1'b0;
      chk("reset_outputs", 32'({ps2_clk_oe, ps2_dat_oe, tx_busy, tx_done, tx_error}), 32'd0);
      return;
    end
    m_req = 1'b0;
    if (m_inh > 0) begin
      m_inh--;
      if (m_inh == 0) m_req = 1'b1;
    end
    if (s_start && !m_busy) begin
      m_busy = 1'b1;
      m_inh  = int'(INH);
    end
    if (ps2_clk_oe) inh_run++;
    if (tx_done || tx_error) begin
      chk("busy_falls_with_pulse", 32'(tx_busy), 32'd0);
      chk("done_err_exclusive", 32'(tx_done & tx_error), 32'd0);
      m_busy = 1'b0;
      n_done += 32'(tx_done);
      n_err  += 32'(tx_error);
      if (tx_error) err_cyc = cyc;
    end else begin
      chk("busy", 32'(tx_busy), 32'(m_busy));
    end
    chk("clk_oe", 32'(ps2_clk_oe), 32'(m_inh > 0));
    if (m_req) chk("request_dat_oe", 32'(ps2_dat_oe), 32'd1);
    else if (!m_busy || m_inh > 0) chk("idle_dat_oe", 32'(ps2_dat_oe), 32'd0);
  endtask

  task automatic send(input logic [7:0] d);
    inh_run  = 0;
    tx_data  = d;
    tx_start = 1'b1;
    tick();
    tx_start = 1'b0;
  endtask

  // Scripted device. stop_at > 0 leaves the clock held low right after that
  // edge; inject_at > 0 issues a second tx_start during that edge's low phase.
  task automatic dev_frame(input int stop_at, input int inject_at, input logic [7:0] inj,
                           input bit ack, output logic [9:0] seq, output int unsigned ecyc);
    int w;
    seq  = '0;
    ecyc = 0;
    w    = 0;
    while (!(ps2_dat_oe && !ps2_clk_oe) && w < int'(INH) + 20) begin
      tick();
      w++;
    end
    chk("request_seen", 32'(ps2_dat_oe && !ps2_clk_oe), 32'd1);
    if (!(ps2_dat_oe && !ps2_clk_oe)) return;
    repeat (4) tick();
    for (int e = 1; e <= 11; e++) begin
      if (e == 11 && ack) begin
        dev_dat = 1'b0;
        repeat (2) tick();
      end
      dev_clk = 1'b0;
      ecyc    = cyc;
      if (e == stop_at) return;
      repeat (HALF) tick();
      if (e <= 10) seq[e-1] = ps2_dat_oe;
      if (e == inject_at) begin
        tx_data  = inj;
        tx_start = 1'b1;
        tick();
        tx_start = 1'b0;
      end
      dev_clk = 1'b1;
      repeat (HALF) tick();
    end
    dev_dat = 1'b1;
  endtask

  task automatic wait_any(input int unsigned base, input int bound);
    int w;
    w = 0;
    while (n_done + n_err == base && w < bound) begin
      tick();
      w++;
    end
  endtask

  initial begin
    logic [9:0]  seq;
    int unsigned ec, bd, be;
    bus_reset = 1'b1;
    tx_start  = 1'b0;
    tx_data   = 8'h00;
    dev_clk   = 1'b1;
    dev_dat   = 1'b1;
    repeat (3) tick();
    bus_reset = 1'b0;
    repeat (3) tick();

    // 0xED: known frame and inhibit length.
    bd = n_done; be = n_err;
    send(8'hED);
    dev_frame(0, 0, 8'h00, 1'b1, seq, ec);
    wait_any(bd + be, 100);
    chk("ED_inhibit_len", inh_run, 32'd40);
    chk("ED_frame_literal", 32'(seq), 32'h012);
    chk("ED_frame_model", 32'(seq), 32'(model_frame(8'hED)));
    chk("ED_done", n_done - bd, 32'd1);
    chk("ED_no_err", n_err - be, 32'd0);
    repeat (5) tick();

    // 0xF4: parity bit 0, so the host pulls data low on edge 9.
    bd = n_done; be = n_err;
    send(8'hF4);
    dev_frame(0, 0, 8'h00, 1'b1, seq, ec);
    wait_any(bd + be, 100);
    chk("F4_parity_oe", 32'(seq[8]), 32'd1);
    chk("F4_frame_model", 32'(seq), 32'(model_frame(8'hF4)));
    chk("F4_done", n_done - bd, 32'd1);
    repeat (5) tick();

    // Missing ACK: data left high at the ACK edge.
    bd = n_done; be = n_err;
    send(8'h55);
    dev_frame(0, 0, 8'h00, 1'b0, seq, ec);
    wait_any(bd + be, 100);
    chk("nack_frame_model", 32'(seq), 32'(model_frame(8'h55)));
    chk("nack_err", n_err - be, 32'd1);
    chk("nack_no_done", n_done - bd, 32'd0);
    chk("nack_lines_released", 32'({ps2_clk_oe, ps2_dat_oe}), 32'd0);
    repeat (5) tick();

    // Device stops clocking after edge 5. The DUT registers an edge three
    // clocks after the line falls (two synchronizer stages plus edge detect).
    bd = n_done; be = n_err;
    send(8'h0F);
    dev_frame(5, 0, 8'h00, 1'b1, seq, ec);
    wait_any(bd + be, int'(TO) + 20);
    chk("timeout_err", n_err - be, 32'd1);
    chk("timeout_latency", err_cyc - ec, TO + 32'd3);
    chk("timeout_no_done", n_done - bd, 32'd0);
    chk("timeout_idle", 32'({tx_busy, ps2_clk_oe, ps2_dat_oe}), 32'd0);
    dev_clk = 1'b1;
    repeat (5) tick();

    // Reset mid-frame at edge 4 (0x81 bit 3 is 0, so data is being pulled low).
    bd = n_done; be = n_err;
    send(8'h81);
    dev_frame(4, 0, 8'h00, 1'b1, seq, ec);
    repeat (HALF / 2) tick();
    chk("pre_reset_dat_oe", 32'(ps2_dat_oe), 32'd1);
    #2 bus_reset = 1'b1;
    #1 chk("reset_async", 32'({ps2_clk_oe, ps2_dat_oe, tx_busy, tx_done, tx_error}), 32'd0);
    repeat (3) tick();
    dev_clk = 1'b1;
    bus_reset = 1'b0;
    repeat (10) tick();
    chk("reset_no_pulses", (n_done - bd) + (n_err - be), 32'd0);
    send(8'h81);
    dev_frame(0, 0, 8'h00, 1'b1, seq, ec);
    wait_any(bd + be, 100);
    chk("post_reset_frame", 32'(seq), 32'(model_frame(8'h81)));
    chk("post_reset_done", n_done - bd, 32'd1);
    repeat (5) tick();

    // A second tx_start during SHIFT must not disturb the frame or start another.
    bd = n_done; be = n_err;
    send(8'hA5);
    dev_frame(0, 3, 8'h3C, 1'b1, seq, ec);
    wait_any(bd + be, 100);
    repeat (INH + 20) tick();
    chk("ignored_start_frame", 32'(seq), 32'(model_frame(8'hA5)));
    chk("ignored_start_one_done", n_done - bd, 32'd1);
    chk("ignored_start_no_err", n_err - be, 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, %0d/%0d checks passed", n_pass, n_total);
    $fatal(1);
  end

endmodule
